// File: rtl/gshare_predictor.sv
// gshare direction predictor: table of N-bit saturating counters indexed by PC[K+1:2] ^ speculative GHR.
// Optional GSHARE_BYPASS_EN: a same-cycle update to the read index is forwarded into the prediction.
module gshare_predictor #(
    parameter int K    = 8,
    parameter int N    = 2,
    parameter int PC_W = 32,
    parameter int INIT = (1 << (N - 1)) - 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pred_valid_i,
    input  logic [PC_W-1:0] pred_pc_i,
    output logic            pred_valid_o,
    output logic            pred_taken_o,
    output logic [K-1:0]    pred_idx_o,
    output logic [K-1:0]    pred_ghr_o,
    input  logic            upd_valid_i,
    input  logic [K-1:0]    upd_idx_i,
    input  logic [K-1:0]    upd_ghr_i,
    input  logic            upd_taken_i,
    input  logic            upd_mispredict_i,
    output logic [K-1:0]    ghr_o
);
    localparam int           DEPTH    = 1 << K;
    localparam logic [N-1:0] CNT_MAX  = '1;
    localparam logic [N-1:0] CNT_INIT = N'(INIT);

    // Both ports are valid-only: no ready, no backpressure; an asserted valid is consumed at the next edge.
    logic [N-1:0] pht [DEPTH];
    logic [K-1:0] ghr;
    logic [K-1:0] idx;
    logic [N-1:0] upd_cnt;
    logic [N-1:0] upd_cnt_next;
    logic [N-1:0] rd_cnt;
    logic         pred_bit;
    logic [K-1:0] ghr_next;
    logic         unused_pc;

    assign idx       = pred_pc_i[K+1:2] ^ ghr;
    // Alignment bits and bits above the hash window never reach the index.
    assign unused_pc = ^pred_pc_i;
    assign upd_cnt   = pht[upd_idx_i];

    always_comb begin
        upd_cnt_next = upd_cnt;
        if (upd_taken_i && (upd_cnt != CNT_MAX)) begin
            upd_cnt_next = upd_cnt + N'(1);
        end else if (!upd_taken_i && (upd_cnt != '0)) begin
            upd_cnt_next = upd_cnt - N'(1);
        end
    end

`ifdef GSHARE_BYPASS_EN
    assign rd_cnt = (upd_valid_i && (upd_idx_i == idx)) ? upd_cnt_next : pht[idx];
`else
    assign rd_cnt = pht[idx];
`endif
    assign pred_bit = rd_cnt[N-1];

    // Repair overrides the speculative shift; the shift form also covers K=1 (history is just the new bit).
    always_comb begin
        ghr_next = ghr;
        if (pred_valid_i) begin
            ghr_next = (ghr << 1) | K'(pred_bit);
        end
        if (upd_valid_i && upd_mispredict_i) begin
            ghr_next = (upd_ghr_i << 1) | K'(upd_taken_i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pht[i] <= CNT_INIT;
            end
            ghr          <= '0;
            pred_valid_o <= 1'b0;
            pred_taken_o <= 1'b0;
            pred_idx_o   <= '0;
            pred_ghr_o   <= '0;
        end else begin
            if (upd_valid_i) begin
                pht[upd_idx_i] <= upd_cnt_next;
            end
            ghr          <= ghr_next;
            pred_valid_o <= pred_valid_i;
            if (pred_valid_i) begin
                pred_taken_o <= pred_bit;
                pred_idx_o   <= idx;
                pred_ghr_o   <= ghr;
            end
        end
    end

    assign ghr_o = ghr;

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor: four instances (K=4/N=2, K=4/N=3 INIT=3, K=4/N=1, K=1/N=2) share stimulus.
// Expectations follow GSHARE_BYPASS_EN for the same-cycle read case.
module tb_gshare_predictor;

`ifdef GSHARE_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        upd_valid;
    logic [3:0]  upd_idx;
    logic [3:0]  upd_ghr;
    logic        upd_taken;
    logic        upd_mispredict;

    logic       m_pv, m_pt;
    logic [3:0] m_pidx, m_pghr, m_ghr;
    logic       n3_pv, n3_pt;
    logic [3:0] n3_pidx, n3_pghr, n3_ghr;
    logic       n1_pv, n1_pt;
    logic [3:0] n1_pidx, n1_pghr, n1_ghr;
    logic       k1_pv, k1_pt;
    logic [0:0] k1_pidx, k1_pghr, k1_ghr;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    gshare_predictor #(.K(4), .N(2), .PC_W(32)) dut (
        .clk(clk), .reset(reset), .pred_valid_i(pred_valid), .pred_pc_i(pred_pc),
        .pred_valid_o(m_pv), .pred_taken_o(m_pt), .pred_idx_o(m_pidx), .pred_ghr_o(m_pghr),
        .upd_valid_i(upd_valid), .upd_idx_i(upd_idx), .upd_ghr_i(upd_ghr), .upd_taken_i(upd_taken),
        .upd_mispredict_i(upd_mispredict), .ghr_o(m_ghr)
    );

    gshare_predictor #(.K(4), .N(3), .PC_W(32), .INIT(3)) dut_n3 (
        .clk(clk), .reset(reset), .pred_valid_i(pred_valid), .pred_pc_i(pred_pc),
        .pred_valid_o(n3_pv), .pred_taken_o(n3_pt), .pred_idx_o(n3_pidx), .pred_ghr_o(n3_pghr),
        .upd_valid_i(upd_valid), .upd_idx_i(upd_idx), .upd_ghr_i(upd_ghr), .upd_taken_i(upd_taken),
        .upd_mispredict_i(upd_mispredict), .ghr_o(n3_ghr)
    );

    gshare_predictor #(.K(4), .N(1), .PC_W(32)) dut_n1 (
        .clk(clk), .reset(reset), .pred_valid_i(pred_valid), .pred_pc_i(pred_pc),
        .pred_valid_o(n1_pv), .pred_taken_o(n1_pt), .pred_idx_o(n1_pidx), .pred_ghr_o(n1_pghr),
        .upd_valid_i(upd_valid), .upd_idx_i(upd_idx), .upd_ghr_i(upd_ghr), .upd_taken_i(upd_taken),
        .upd_mispredict_i(upd_mispredict), .ghr_o(n1_ghr)
    );

    gshare_predictor #(.K(1), .N(2), .PC_W(32)) dut_k1 (
        .clk(clk), .reset(reset), .pred_valid_i(pred_valid), .pred_pc_i(pred_pc),
        .pred_valid_o(k1_pv), .pred_taken_o(k1_pt), .pred_idx_o(k1_pidx), .pred_ghr_o(k1_pghr),
        .upd_valid_i(upd_valid), .upd_idx_i(upd_idx[0:0]), .upd_ghr_i(upd_ghr[0:0]), .upd_taken_i(upd_taken),
        .upd_mispredict_i(upd_mispredict), .ghr_o(k1_ghr)
    );

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        pred_valid     = 1'b0;
        pred_pc        = '0;
        upd_valid      = 1'b0;
        upd_idx        = '0;
        upd_ghr        = '0;
        upd_taken      = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic req(input logic [31:0] pc);
        pred_valid = 1'b1;
        pred_pc    = pc;
    endtask

    task automatic upd(input logic [3:0] i, input logic [3:0] g, input logic t, input logic m);
        upd_valid      = 1'b1;
        upd_idx        = i;
        upd_ghr        = g;
        upd_taken      = t;
        upd_mispredict = m;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        total++; if (m_pv !== 1'b0) $display("FAIL rst_pv: got %0h want 0", m_pv); else passed++;
        total++; if (m_pt !== 1'b0) $display("FAIL rst_pt: got %0h want 0", m_pt); else passed++;
        total++; if (m_pidx !== 4'h0) $display("FAIL rst_pidx: got %0h want 0", m_pidx); else passed++;
        total++; if (m_ghr !== 4'h0) $display("FAIL rst_ghr: got %0h want 0", m_ghr); else passed++;
        req(32'h40);
        step();
        total++; if (m_pv !== 1'b1) $display("FAIL p40_pv: got %0h want 1", m_pv); else passed++;
        total++; if (m_pt !== 1'b0) $display("FAIL p40_pt: got %0h want 0", m_pt); else passed++;
        total++; if (m_pidx !== 4'h0) $display("FAIL p40_pidx: got %0h want 0", m_pidx); else passed++;
        total++; if (m_pghr !== 4'h0) $display("FAIL p40_pghr: got %0h want 0", m_pghr); else passed++;
        total++; if (m_ghr !== 4'h0) $display("FAIL p40_ghr: got %0h want 0", m_ghr); else passed++;
        step();
        total++; if (m_pv !== 1'b0) $display("FAIL p40_pv_drop: got %0h want 0", m_pv); else passed++;
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            upd(4'h5, 4'h0, 1'b1, 1'b0);
            step();
        end
        req(32'h14);                     // ghr 0 -> idx 5, counter 3
        step();
        total++; if (m_pt !== 1'b1) $display("FAIL sat_hi_pt: got %0h want 1", m_pt); else passed++;
        total++; if (m_pidx !== 4'h5) $display("FAIL sat_hi_pidx: got %0h want 5", m_pidx); else passed++;
        total++; if (m_ghr !== 4'h1) $display("FAIL sat_hi_ghr: got %0h want 1", m_ghr); else passed++;
        upd(4'h5, 4'h0, 1'b0, 1'b0);     // 3 -> 2
        step();
        total++; if (m_pv !== 1'b0) $display("FAIL hold_pv: got %0h want 0", m_pv); else passed++;
        total++; if (m_pidx !== 4'h5) $display("FAIL hold_pidx: got %0h want 5", m_pidx); else passed++;
        total++; if (m_pt !== 1'b1) $display("FAIL hold_pt: got %0h want 1", m_pt); else passed++;
        req(32'h10);                     // ghr 1 -> idx 5, counter 2
        step();
        total++; if (m_pt !== 1'b1) $display("FAIL sat_2_pt: got %0h want 1", m_pt); else passed++;
        total++; if (m_pidx !== 4'h5) $display("FAIL sat_2_pidx: got %0h want 5", m_pidx); else passed++;
        total++; if (m_pghr !== 4'h1) $display("FAIL sat_2_pghr: got %0h want 1", m_pghr); else passed++;
        total++; if (m_ghr !== 4'h3) $display("FAIL sat_2_ghr: got %0h want 3", m_ghr); else passed++;
        for (int i = 0; i < 3; i++) begin  // 2 -> 1 -> 0 -> 0
            upd(4'h5, 4'h0, 1'b0, 1'b0);
            step();
        end
        upd(4'h5, 4'h0, 1'b1, 1'b0);     // 0 -> 1
        step();
        req(32'h18);                     // ghr 3 -> idx 5, counter 1
        step();
        total++; if (m_pt !== 1'b0) $display("FAIL sat_lo_pt: got %0h want 0", m_pt); else passed++;
        total++; if (m_pidx !== 4'h5) $display("FAIL sat_lo_pidx: got %0h want 5", m_pidx); else passed++;
        total++; if (m_ghr !== 4'h6) $display("FAIL sat_lo_ghr: got %0h want 6", m_ghr); else passed++;
        upd(4'h5, 4'h0, 1'b1, 1'b0);     // 1 -> 2
        step();
        req(32'h0C);                     // ghr 6 -> idx 5, counter 2
        step();
        total++; if (m_pt !== 1'b1) $display("FAIL sat_up_pt: got %0h want 1", m_pt); else passed++;
        total++; if (m_pidx !== 4'h5) $display("FAIL sat_up_pidx: got %0h want 5", m_pidx); else passed++;
        total++; if (m_ghr !== 4'hD) $display("FAIL sat_up_ghr: got %0h want d", m_ghr); else passed++;
    endtask

    task automatic test_widths();
        do_reset();
        req(32'h14);
        step();
        total++; if (n3_pv !== 1'b1) $display("FAIL w0_n3_pv: got %0h want 1", n3_pv); else passed++;
        total++; if (n1_pv !== 1'b1) $display("FAIL w0_n1_pv: got %0h want 1", n1_pv); else passed++;
        total++; if (n3_pt !== 1'b0) $display("FAIL w0_n3_pt: got %0h want 0", n3_pt); else passed++;
        total++; if (n1_pt !== 1'b0) $display("FAIL w0_n1_pt: got %0h want 0", n1_pt); else passed++;
        total++; if (k1_pv !== 1'b1) $display("FAIL w0_k1_pv: got %0h want 1", k1_pv); else passed++;
        total++; if (k1_pt !== 1'b0) $display("FAIL w0_k1_pt: got %0h want 0", k1_pt); else passed++;
        total++; if (k1_pidx !== 1'b1) $display("FAIL w0_k1_pidx: got %0h want 1", k1_pidx); else passed++;
        total++; if (k1_ghr !== 1'b0) $display("FAIL w0_k1_ghr: got %0h want 0", k1_ghr); else passed++;
        upd(4'h5, 4'h0, 1'b1, 1'b0);     // n3 3->4, n1 0->1, k1 idx1 1->2
        step();
        req(32'h14);
        step();
        total++; if (n3_pt !== 1'b1) $display("FAIL w1_n3_pt: got %0h want 1", n3_pt); else passed++;
        total++; if (n1_pt !== 1'b1) $display("FAIL w1_n1_pt: got %0h want 1", n1_pt); else passed++;
        total++; if (k1_pt !== 1'b1) $display("FAIL w1_k1_pt: got %0h want 1", k1_pt); else passed++;
        total++; if (k1_ghr !== 1'b1) $display("FAIL w1_k1_ghr: got %0h want 1", k1_ghr); else passed++;
        total++; if (n1_ghr !== 4'h1) $display("FAIL w1_n1_ghr: got %0h want 1", n1_ghr); else passed++;
        upd(4'h5, 4'h0, 1'b0, 1'b0);     // n3 4->3, n1 1->0, k1 2->1
        step();
        req(32'h10);                     // K=4: idx 4^1=5; K=1: idx 0^1=1
        step();
        total++; if (n3_pt !== 1'b0) $display("FAIL w2_n3_pt: got %0h want 0", n3_pt); else passed++;
        total++; if (n3_pidx !== 4'h5) $display("FAIL w2_n3_pidx: got %0h want 5", n3_pidx); else passed++;
        total++; if (n3_pghr !== 4'h1) $display("FAIL w2_n3_pghr: got %0h want 1", n3_pghr); else passed++;
        total++; if (n3_ghr !== 4'h2) $display("FAIL w2_n3_ghr: got %0h want 2", n3_ghr); else passed++;
        total++; if (n1_pt !== 1'b0) $display("FAIL w2_n1_pt: got %0h want 0", n1_pt); else passed++;
        total++; if (n1_pidx !== 4'h5) $display("FAIL w2_n1_pidx: got %0h want 5", n1_pidx); else passed++;
        total++; if (n1_pghr !== 4'h1) $display("FAIL w2_n1_pghr: got %0h want 1", n1_pghr); else passed++;
        total++; if (k1_pt !== 1'b0) $display("FAIL w2_k1_pt: got %0h want 0", k1_pt); else passed++;
        total++; if (k1_pidx !== 1'b1) $display("FAIL w2_k1_pidx: got %0h want 1", k1_pidx); else passed++;
        total++; if (k1_pghr !== 1'b1) $display("FAIL w2_k1_pghr: got %0h want 1", k1_pghr); else passed++;
        total++; if (k1_ghr !== 1'b0) $display("FAIL w2_k1_ghr: got %0h want 0", k1_ghr); else passed++;
    endtask

    task automatic test_history_repair();
        do_reset();
        upd(4'h0, 4'h0, 1'b1, 1'b0);     // idx 0: 1 -> 2
        step();
        req(32'h00);
        step();
        total++; if (m_pt !== 1'b1) $display("FAIL h0_pt: got %0h want 1", m_pt); else passed++;
        total++; if (m_ghr !== 4'h1) $display("FAIL h0_ghr: got %0h want 1", m_ghr); else passed++;
        req(32'h40);                     // idx 0^1=1, INIT
        step();
        total++; if (m_pt !== 1'b0) $display("FAIL h1_pt: got %0h want 0", m_pt); else passed++;
        total++; if (m_pidx !== 4'h1) $display("FAIL h1_pidx: got %0h want 1", m_pidx); else passed++;
        total++; if (m_pghr !== 4'h1) $display("FAIL h1_pghr: got %0h want 1", m_pghr); else passed++;
        total++; if (m_ghr !== 4'h2) $display("FAIL h1_ghr: got %0h want 2", m_ghr); else passed++;
        req(32'h0C);                     // idx 3^2=1 with pre-edge ghr
        upd(4'h9, 4'b0110, 1'b1, 1'b1);  // repair wins: ghr <- 1101
        step();
        total++; if (m_pv !== 1'b1) $display("FAIL rep_pv: got %0h want 1", m_pv); else passed++;
        total++; if (m_pt !== 1'b0) $display("FAIL rep_pt: got %0h want 0", m_pt); else passed++;
        total++; if (m_pidx !== 4'h1) $display("FAIL rep_pidx: got %0h want 1", m_pidx); else passed++;
        total++; if (m_pghr !== 4'h2) $display("FAIL rep_pghr: got %0h want 2", m_pghr); else passed++;
        total++; if (m_ghr !== 4'hD) $display("FAIL rep_ghr: got %0h want d", m_ghr); else passed++;
        upd_mispredict = 1'b1;           // no upd_valid: must be ignored
        upd_ghr        = 4'hF;
        upd_taken      = 1'b0;
        step();
        total++; if (m_ghr !== 4'hD) $display("FAIL rep_novalid_ghr: got %0h want d", m_ghr); else passed++;
        req(32'h10);                     // idx 4^D=9, counter 2 from the repair update
        step();
        total++; if (m_pt !== 1'b1) $display("FAIL rep_upd_pt: got %0h want 1", m_pt); else passed++;
        total++; if (m_pidx !== 4'h9) $display("FAIL rep_upd_pidx: got %0h want 9", m_pidx); else passed++;
        total++; if (m_ghr !== 4'hB) $display("FAIL rep_upd_ghr: got %0h want b", m_ghr); else passed++;
    endtask

    task automatic test_bypass();
        do_reset();
        req(32'h14);
        upd(4'h5, 4'h0, 1'b1, 1'b0);
        step();
        total++; if (m_pt !== BYP) $display("FAIL byp_pt: got %0h want %0h", m_pt, BYP); else passed++;
        total++; if (n3_pt !== BYP) $display("FAIL byp_n3_pt: got %0h want %0h", n3_pt, BYP); else passed++;
        total++; if (n1_pt !== BYP) $display("FAIL byp_n1_pt: got %0h want %0h", n1_pt, BYP); else passed++;
        total++; if (m_ghr !== {3'b000, BYP}) $display("FAIL byp_ghr: got %0h want %0h", m_ghr, BYP); else passed++;
        req(BYP ? 32'h10 : 32'h14);      // land on idx 5 again
        step();
        total++; if (m_pt !== 1'b1) $display("FAIL byp_after_pt: got %0h want 1", m_pt); else passed++;
        total++; if (m_pidx !== 4'h5) $display("FAIL byp_after_pidx: got %0h want 5", m_pidx); else passed++;
        total++; if (n3_pt !== 1'b1) $display("FAIL byp_after_n3_pt: got %0h want 1", n3_pt); else passed++;
    endtask

    task automatic test_reset_midflight();
        do_reset();
        upd(4'h5, 4'h0, 1'b1, 1'b0);
        step();
        upd(4'h5, 4'h0, 1'b1, 1'b0);     // idx 5 now 3
        step();
        req(32'h14);
        upd(4'h5, 4'h0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++; if (m_pv !== 1'b0) $display("FAIL mid_pv: got %0h want 0", m_pv); else passed++;
        total++; if (m_ghr !== 4'h0) $display("FAIL mid_ghr: got %0h want 0", m_ghr); else passed++;
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
        req(32'h14);
        step();
        total++; if (m_pv !== 1'b1) $display("FAIL mid_after_pv: got %0h want 1", m_pv); else passed++;
        total++; if (m_pt !== 1'b0) $display("FAIL mid_after_pt: got %0h want 0", m_pt); else passed++;
        total++; if (m_pidx !== 4'h5) $display("FAIL mid_after_pidx: got %0h want 5", m_pidx); else passed++;
        total++; if (n3_pt !== 1'b0) $display("FAIL mid_after_n3_pt: got %0h want 0", n3_pt); else passed++;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_saturate();
        test_widths();
        test_history_repair();
        test_bypass();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
